// File: rtl/nav_event_arbiter.sv
// Merges debounced button pulses and FFT pitch edges into one ordered command stream.
// FFT events pass through a holdoff lockout; commands leave via a small FWFT FIFO.
module nav_event_arbiter #(
    parameter int DEPTH          = 4,
    parameter int HOLDOFF_CYCLES = 25_000_000
) (
    input  logic       clk_100mhz,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    input  logic       fft_hi,
    input  logic       fft_lo,
    input  logic       fft_enable,
    input  logic       flush,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    output logic       cmd_src,
    output logic       fft_locked,
    output logic [7:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLDOFF_CYCLES - 1);

    localparam logic [1:0] CODE_UP     = 2'd0;
    localparam logic [1:0] CODE_DOWN   = 2'd1;
    localparam logic [1:0] CODE_SELECT = 2'd2;

    // Handshake: a command transfers on every clock edge where cmd_valid && cmd_ready;
    // cmd_code/cmd_src are stable while cmd_valid is high and not yet accepted.

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} hold_state_t;

    hold_state_t   state, state_next;
    logic [CW-1:0] hold_cnt, hold_cnt_next;

    logic fft_hi_q, fft_lo_q;
    logic hi_edge, lo_edge, fft_live, fft_any;

    logic       push_req, fft_sel, loser;
    logic [1:0] push_code;
    logic       push_src;

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
    logic [AW:0]   count, count_next, count_after_pop;
    logic          full, pop, push_ok, lost_full, drop_inc;

    assign hi_edge  = fft_hi & ~fft_hi_q;
    assign lo_edge  = fft_lo & ~fft_lo_q;
    assign fft_live = fft_enable && (state == IDLE);
    assign fft_any  = fft_live && (hi_edge || lo_edge);

    // Edge registers track the levels unconditionally so enabling never fabricates an edge.
    always_ff @(posedge clk_100mhz) begin
        fft_hi_q <= fft_hi;
        fft_lo_q <= fft_lo;
    end

    always_comb begin
        push_req  = 1'b0;
        push_code = CODE_UP;
        push_src  = 1'b0;
        fft_sel   = 1'b0;
        if (btn_sel) begin
            push_req  = 1'b1;
            push_code = CODE_SELECT;
        end else if (btn_up ^ btn_down) begin
            push_req  = 1'b1;
            push_code = btn_up ? CODE_UP : CODE_DOWN;
        end else if (fft_live && (hi_edge ^ lo_edge)) begin
            push_req  = 1'b1;
            push_code = hi_edge ? CODE_UP : CODE_DOWN;
            push_src  = 1'b1;
            fft_sel   = 1'b1;
        end
    end

    always_comb begin
        if (btn_sel)
            loser = btn_up || btn_down || fft_any;
        else if (btn_up ^ btn_down)
            loser = fft_any;
        else if (fft_sel)
            loser = btn_up && btn_down;
        else
            loser = (btn_up && btn_down) || fft_any;
    end

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        if (!fft_enable) begin
            state_next    = IDLE;
            hold_cnt_next = '0;
        end else begin
            case (state)
                IDLE: if (fft_sel) begin
                    state_next    = HOLD;
                    hold_cnt_next = HOLD_LOAD;
                end
                HOLD: if (hold_cnt == '0) state_next = IDLE;
                      else hold_cnt_next = hold_cnt - 1'b1;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    assign fft_locked = (state == HOLD);

    assign cmd_valid       = (count != '0);
    assign full            = (count == FULL_COUNT);
    assign pop             = cmd_valid && cmd_ready;
    assign push_ok         = push_req && (!full || pop) && !flush;
    assign lost_full       = push_req && full && !pop && !flush;
    assign drop_inc        = loser || lost_full;
    assign rd_ptr_next     = rd_ptr + AW'(pop);
    assign count_after_pop = count - (AW+1)'(pop);
    assign count_next      = count_after_pop + (AW+1)'(push_ok);

    // Head register: takes the fresh push when it lands in an otherwise empty queue.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cmd_code <= CODE_UP;
            cmd_src  <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {push_code, push_src};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            if (count_next != '0) begin
                if (count_after_pop == '0)
                    {cmd_code, cmd_src} <= {push_code, push_src};
                else
                    {cmd_code, cmd_src} <= mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset)
            drop_count <= '0;
        else if (drop_inc && drop_count != 8'hFF)
            drop_count <= drop_count + 1'b1;
    end

endmodule

// File: tb/tb_nav_event_arbiter.sv
// Bench for nav_event_arbiter: a directed vector table, then random traffic
// compared each cycle against a queue-based model of the command rules.
module tb_nav_event_arbiter;

    localparam int DEPTH = 4;
    localparam int HOLD  = 10;

    logic       clk_100mhz = 1'b0;
    logic       reset, btn_up, btn_down, btn_sel, fft_hi, fft_lo, fft_enable, flush, cmd_ready;
    logic       cmd_valid, cmd_src, fft_locked;
    logic [1:0] cmd_code;
    logic [7:0] drop_count;

    always #5 clk_100mhz = ~clk_100mhz;

    nav_event_arbiter #(.DEPTH(DEPTH), .HOLDOFF_CYCLES(HOLD)) dut (
        .clk_100mhz(clk_100mhz), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
        .fft_hi(fft_hi), .fft_lo(fft_lo), .fft_enable(fft_enable),
        .flush(flush), .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_src(cmd_src),
        .fft_locked(fft_locked), .drop_count(drop_count)
    );

    typedef struct packed {
        logic rst, up, down, sel, hi, lo, en, fl, rdy;
    } in_t;

    typedef struct {
        in_t        i;
        logic       v;
        logic [1:0] code;
        logic       src;
        logic       lk;
        int         drop;
    } vec_t;

    typedef struct packed {
        logic [1:0] code;
        logic       src;
    } cmd_t;

    cmd_t m_q[$];
    int   m_lock, m_drop;
    logic m_prev_hi, m_prev_lo;
    int   n_vec, n_bad;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [8:0] iv, input logic v, input logic [1:0] c,
                                input logic s, input logic lk, input int d);
        vec_t r;
        r.i = in_t'(iv); r.v = v; r.code = c; r.src = s; r.lk = lk; r.drop = d;
        return r;
    endfunction

    task automatic apply(input in_t x);
        reset = x.rst; btn_up = x.up; btn_down = x.down; btn_sel = x.sel;
        fft_hi = x.hi; fft_lo = x.lo; fft_enable = x.en; flush = x.fl; cmd_ready = x.rdy;
    endtask

    // One clock of the command rules: count events, pick the winner, then queue it.
    function automatic void model_step(input in_t x);
        int   n_ev;
        logic eligible, he, le, has_win, fft_win, lost, was_full, popped;
        cmd_t win;
        if (x.rst) begin
            m_q.delete(); m_lock = 0; m_drop = 0;
            m_prev_hi = x.hi; m_prev_lo = x.lo;
            return;
        end
        eligible = x.en && (m_lock == 0);
        he = x.hi && !m_prev_hi;
        le = x.lo && !m_prev_lo;
        n_ev = int'(x.sel) + int'(x.up) + int'(x.down) + (eligible ? int'(he) + int'(le) : 0);
        has_win = 1'b1; fft_win = 1'b0; win = '0;
        if (x.sel)              win = '{2'd2, 1'b0};
        else if (x.up != x.down) win = '{x.up ? 2'd0 : 2'd1, 1'b0};
        else if (eligible && he != le) begin
            win = '{he ? 2'd0 : 2'd1, 1'b1};
            fft_win = 1'b1;
        end else has_win = 1'b0;
        lost = (n_ev > (has_win ? 1 : 0));
        if (x.fl) m_q.delete();
        else begin
            was_full = (m_q.size() == DEPTH);
            popped = (m_q.size() > 0) && x.rdy;
            if (popped) void'(m_q.pop_front());
            if (has_win) begin
                if (!was_full || popped) m_q.push_back(win);
                else lost = 1'b1;
            end
        end
        if (lost && m_drop < 255) m_drop++;
        if (!x.en)           m_lock = 0;
        else if (m_lock > 0) m_lock--;
        else if (fft_win)    m_lock = HOLD;
        m_prev_hi = x.hi; m_prev_lo = x.lo;
    endfunction

    task automatic check_out(input string name, input logic v, input logic [1:0] c,
                             input logic s, input logic lk, input int d);
        logic bad;
        n_vec++;
        bad = (cmd_valid !== v) || (fft_locked !== lk) || (drop_count !== 8'(d)) ||
              (v && ((cmd_code !== c) || (cmd_src !== s)));
        if (bad) begin
            n_bad++;
            $display("FAIL %s t=%0t: got valid=%b code=%0d src=%b locked=%b drops=%0d, want valid=%b code=%0d src=%b locked=%b drops=%0d",
                     name, $time, cmd_valid, cmd_code, cmd_src, fft_locked, drop_count,
                     v, c, s, lk, d);
        end
    endtask

    task automatic step(input in_t x);
        cmd_t h;
        apply(x);
        @(posedge clk_100mhz);
        model_step(x);
        @(negedge clk_100mhz);
        h = (m_q.size() > 0) ? m_q[0] : '0;
        check_out("model", m_q.size() > 0, h.code, h.src, m_lock > 0, m_drop);
    endtask

    initial begin
        in_t  x;
        logic lvl_hi, lvl_lo, en;
        int   rdy_pct;
        n_vec = 0; n_bad = 0;
        m_q.delete(); m_lock = 0; m_drop = 0; m_prev_hi = 1'b0; m_prev_lo = 1'b0;
        apply('0);
        reset = 1'b1;
        @(negedge clk_100mhz);

        // bits: rst _ up down sel _ hi lo _ en _ flush rdy
        tbl.push_back(mk(9'b1_000_00_0_00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(9'b0_100_00_0_00, 1, 0, 0, 0, 0));
        tbl.push_back(mk(9'b0_000_00_0_01, 0, 0, 0, 0, 0));
        tbl.push_back(mk(9'b0_000_00_0_00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(9'b0_000_00_1_00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(9'b0_000_10_1_00, 1, 0, 1, 1, 0));
        tbl.push_back(mk(9'b0_000_10_1_01, 0, 0, 0, 1, 0));
        tbl.push_back(mk(9'b0_000_00_1_00, 0, 0, 0, 1, 0));
        tbl.push_back(mk(9'b0_000_00_1_00, 0, 0, 0, 1, 0));
        tbl.push_back(mk(9'b0_000_10_1_00, 0, 0, 0, 1, 0));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(9'b0_000_00_1_00, 0, 0, 0, 1, 0));
        tbl.push_back(mk(9'b0_000_00_1_00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(9'b0_000_10_1_00, 1, 0, 1, 1, 0));
        tbl.push_back(mk(9'b0_000_00_0_01, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(9'b0_010_00_0_00, 1, 1, 0, 0, 0));
        tbl.push_back(mk(9'b0_010_00_0_00, 1, 1, 0, 0, 1));
        tbl.push_back(mk(9'b0_010_00_0_00, 1, 1, 0, 0, 2));
        tbl.push_back(mk(9'b0_100_00_0_01, 1, 1, 0, 0, 2));
        tbl.push_back(mk(9'b0_000_00_0_01, 1, 1, 0, 0, 2));
        tbl.push_back(mk(9'b0_000_00_0_01, 1, 1, 0, 0, 2));
        tbl.push_back(mk(9'b0_000_00_0_01, 1, 0, 0, 0, 2));
        tbl.push_back(mk(9'b0_000_00_0_01, 0, 0, 0, 0, 2));
        tbl.push_back(mk(9'b0_000_00_1_00, 0, 0, 0, 0, 2));
        tbl.push_back(mk(9'b0_001_01_1_00, 1, 2, 0, 0, 3));
        tbl.push_back(mk(9'b0_110_01_1_00, 1, 2, 0, 0, 4));
        tbl.push_back(mk(9'b0_000_00_1_01, 0, 0, 0, 0, 4));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(9'b0_100_00_1_00, 1, 0, 0, 0, 4));
        tbl.push_back(mk(9'b0_100_00_1_10, 0, 0, 0, 0, 4));
        tbl.push_back(mk(9'b0_000_00_1_00, 0, 0, 0, 0, 4));
        tbl.push_back(mk(9'b1_000_10_1_00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(9'b0_000_10_1_00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(9'b0_000_00_1_00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(9'b0_000_10_1_00, 1, 0, 1, 1, 0));
        tbl.push_back(mk(9'b0_000_10_0_00, 1, 0, 1, 0, 0));
        tbl.push_back(mk(9'b0_000_10_1_00, 1, 0, 1, 0, 0));
        tbl.push_back(mk(9'b0_000_00_1_01, 0, 0, 0, 0, 0));
        tbl.push_back(mk(9'b0_000_00_1_00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(9'b0_000_10_1_00, 1, 0, 1, 1, 0));
        tbl.push_back(mk(9'b1_000_10_1_00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(9'b0_000_10_1_00, 0, 0, 0, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].i);
            check_out($sformatf("vec%0d", k), tbl[k].v, tbl[k].code, tbl[k].src,
                      tbl[k].lk, tbl[k].drop);
        end

        // Random traffic; level inputs toggle rarely so the holdoff gets exercised.
        lvl_hi = 1'b1; lvl_lo = 1'b0; en = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rdy_pct = ((n / 400) % 2 == 0) ? 70 : 20;
            if ($urandom_range(0, 7) == 0)  lvl_hi = ~lvl_hi;
            if ($urandom_range(0, 9) == 0)  lvl_lo = ~lvl_lo;
            if ($urandom_range(0, 59) == 0) en = ~en;
            x.rst  = ($urandom_range(0, 699) == 0);
            x.up   = ($urandom_range(0, 4) == 0);
            x.down = ($urandom_range(0, 4) == 0);
            x.sel  = ($urandom_range(0, 9) == 0);
            x.hi   = lvl_hi;
            x.lo   = lvl_lo;
            x.en   = en;
            x.fl   = 1'b0;
            x.rdy  = ($urandom_range(0, 99) < rdy_pct);
            step(x);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
